// File: rtl/packet_check_pkg.sv
// -----------------------------------------------------------------------------
// packet_check_pkg
// Shared definitions for the test-packet checker: register indices, AXI
// response codes, address mask, FSM state types and small saturating helpers.
// -----------------------------------------------------------------------------
package packet_check_pkg;

    // Register word indices (byte address & ADDR_MASK, >> 2). They match the
    // generator's indices wherever the meaning is the same.
    localparam logic [4:0] REG_MODULE_REV     = 5'd0;
    localparam logic [4:0] REG_PKT_COUNT_H    = 5'd1;
    localparam logic [4:0] REG_PKT_COUNT_L    = 5'd2;
    localparam logic [4:0] REG_CYCLES_PER_PKT = 5'd3;
    localparam logic [4:0] REG_DATA_ERRS      = 5'd4;
    localparam logic [4:0] REG_LEN_ERRS       = 5'd5;
    localparam logic [4:0] REG_CONTROL        = 5'd6;
    localparam logic [4:0] REG_FIRST_BAD_SEQ  = 5'd7;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [6:0] ADDR_MASK = 7'h7F;

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_DATA } rd_state_t;

    // Word index of a byte address inside the register window.
    function automatic logic [4:0] reg_index(input logic [6:0] byte_addr);
        return 5'((byte_addr & ADDR_MASK) >> 2);
    endfunction

    // 32-bit counter step that sticks at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 32'd1 : v;
    endfunction

    // 64-bit counter step that sticks at all-ones.
    function automatic logic [63:0] sat_inc64(input logic [63:0] v);
        return (v != '1) ? v + 64'd1 : v;
    endfunction

endpackage

// File: rtl/axi4_lite_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave
// AXI4-Lite slave front end. Converts the five AXI channels into the simple
// ashi_* handshake: a one-cycle o_ashi_write / o_ashi_read strobe with the
// address (and write data), answered combinationally by the register file
// through i_ashi_wresp / i_ashi_rdata / i_ashi_rresp. Writes complete in one
// cycle of W_IDLE when AW and W are both valid.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_aw* / i_w* / o_b* AXI write address, data and response channels
//   i_ar* / o_r*        AXI read address and data channels
//   o_ashi_* / i_ashi_* register-file handshake
// -----------------------------------------------------------------------------
module axi4_lite_slave
    import packet_check_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_awaddr,
    input  logic [2:0]  i_awprot,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready,
    input  logic [31:0] i_araddr,
    input  logic [2:0]  i_arprot,
    input  logic        i_arvalid,
    output logic        o_arready,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic [31:0] o_ashi_waddr,
    output logic [31:0] o_ashi_wdata,
    output logic [3:0]  o_ashi_wstrb,
    output logic        o_ashi_write,
    input  logic [1:0]  i_ashi_wresp,
    output logic [31:0] o_ashi_raddr,
    output logic        o_ashi_read,
    input  logic [31:0] i_ashi_rdata,
    input  logic [1:0]  i_ashi_rresp
);

    wr_state_t   r_wstate;
    rd_state_t   r_rstate;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic w_write;
    logic w_read;
    logic w_unused;

    // Address and data are taken together, so a write is one strobe.
    assign w_write = (r_wstate == W_IDLE) && i_awvalid && i_wvalid;
    assign w_read  = (r_rstate == R_IDLE) && i_arvalid;

    assign o_awready    = w_write;
    assign o_wready     = w_write;
    assign o_arready    = w_read;
    assign o_ashi_write = w_write;
    assign o_ashi_read  = w_read;
    assign o_ashi_waddr = i_awaddr;
    assign o_ashi_wdata = i_wdata;
    assign o_ashi_wstrb = i_wstrb;
    assign o_ashi_raddr = i_araddr;

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rresp  = r_rresp;
    assign o_rdata  = r_rdata;

    // Protection attributes carry no meaning for this register file.
    assign w_unused = ^{i_awprot, i_arprot};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_write) begin
                    r_bresp  <= i_ashi_wresp;
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: if (i_bready) begin
                    r_bvalid <= 1'b0;
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rresp  <= OKAY;
            r_rdata  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_read) begin
                    r_rdata  <= i_ashi_rdata;
                    r_rresp  <= i_ashi_rresp;
                    r_rvalid <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: if (i_rready) begin
                    r_rvalid <= 1'b0;
                    r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/packet_check.sv
// -----------------------------------------------------------------------------
// packet_check
// Receive end of the 512-bit AXI-Stream test-packet link. Each beat must carry
// {16{seq}} with all TKEEP bits set; seq starts at 1 and steps once per packet.
// Packet length is checked against CYCLES_PER_PKT latched at beat 1. Good
// packets and errors are counted and exposed over AXI4-Lite.
// Ports:
//   clk, resetn       clock, async active-low reset
//   S_AXI_*           AXI4-Lite register slave
//   AXIS_IN_*         incoming stream (TREADY registered, high after reset)
//   ERROR             high while DATA_ERRS or LEN_ERRS is non-zero
// -----------------------------------------------------------------------------
module packet_check
    import packet_check_pkg::*;
#(
    parameter int unsigned DEFAULT_CYCLES_PER_PKT = 3,
    parameter int unsigned MODULE_VERSION         = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [31:0]  S_AXI_AWADDR,
    input  logic [2:0]   S_AXI_AWPROT,
    input  logic         S_AXI_AWVALID,
    output logic         S_AXI_AWREADY,
    input  logic [31:0]  S_AXI_WDATA,
    input  logic [3:0]   S_AXI_WSTRB,
    input  logic         S_AXI_WVALID,
    output logic         S_AXI_WREADY,
    output logic [1:0]   S_AXI_BRESP,
    output logic         S_AXI_BVALID,
    input  logic         S_AXI_BREADY,
    input  logic [31:0]  S_AXI_ARADDR,
    input  logic [2:0]   S_AXI_ARPROT,
    input  logic         S_AXI_ARVALID,
    output logic         S_AXI_ARREADY,
    output logic [31:0]  S_AXI_RDATA,
    output logic [1:0]   S_AXI_RRESP,
    output logic         S_AXI_RVALID,
    input  logic         S_AXI_RREADY,
    input  logic [511:0] AXIS_IN_TDATA,
    input  logic [63:0]  AXIS_IN_TKEEP,
    input  logic         AXIS_IN_TLAST,
    input  logic         AXIS_IN_TVALID,
    output logic         AXIS_IN_TREADY,
    output logic         ERROR
);

    // ashi handshake from the AXI front end
    logic [31:0] w_ashi_waddr;
    logic [31:0] w_ashi_wdata;
    logic [3:0]  w_ashi_wstrb;
    logic        w_ashi_write;
    logic [1:0]  w_ashi_wresp;
    logic [31:0] w_ashi_raddr;
    logic        w_ashi_read;
    logic [31:0] w_ashi_rdata;
    logic [1:0]  w_ashi_rresp;

    axi4_lite_slave axi_slave (
        .clk          (clk),
        .rst_n        (resetn),
        .i_awaddr     (S_AXI_AWADDR),
        .i_awprot     (S_AXI_AWPROT),
        .i_awvalid    (S_AXI_AWVALID),
        .o_awready    (S_AXI_AWREADY),
        .i_wdata      (S_AXI_WDATA),
        .i_wstrb      (S_AXI_WSTRB),
        .i_wvalid     (S_AXI_WVALID),
        .o_wready     (S_AXI_WREADY),
        .o_bresp      (S_AXI_BRESP),
        .o_bvalid     (S_AXI_BVALID),
        .i_bready     (S_AXI_BREADY),
        .i_araddr     (S_AXI_ARADDR),
        .i_arprot     (S_AXI_ARPROT),
        .i_arvalid    (S_AXI_ARVALID),
        .o_arready    (S_AXI_ARREADY),
        .o_rdata      (S_AXI_RDATA),
        .o_rresp      (S_AXI_RRESP),
        .o_rvalid     (S_AXI_RVALID),
        .i_rready     (S_AXI_RREADY),
        .o_ashi_waddr (w_ashi_waddr),
        .o_ashi_wdata (w_ashi_wdata),
        .o_ashi_wstrb (w_ashi_wstrb),
        .o_ashi_write (w_ashi_write),
        .i_ashi_wresp (w_ashi_wresp),
        .o_ashi_raddr (w_ashi_raddr),
        .o_ashi_read  (w_ashi_read),
        .i_ashi_rdata (w_ashi_rdata),
        .i_ashi_rresp (w_ashi_rresp)
    );

    // Checker and register state
    logic        r_tready;
    logic [63:0] r_expected_seq;
    logic [15:0] r_beat;
    logic [15:0] r_pkt_cpp;
    logic        r_data_bad;
    logic        r_len_bad;
    logic [63:0] r_pkt_count;
    logic [31:0] r_pkt_count_h;
    logic [31:0] r_data_errs;
    logic [31:0] r_len_errs;
    logic [31:0] r_first_bad;
    logic [15:0] r_cpp;

    logic [4:0]  w_widx;
    logic [4:0]  w_ridx;
    logic        w_cpp_we;
    logic        w_clear;
    logic        w_latch_h;
    logic        w_accept;
    logic [15:0] w_cpp_live;
    logic [15:0] w_cpp;
    logic        w_data_bad;
    logic        w_long;
    logic        w_len_bad;
    logic        w_unused;

    assign w_widx = reg_index(w_ashi_waddr[6:0]);
    assign w_ridx = reg_index(w_ashi_raddr[6:0]);

    // Bits the register map never decodes.
    assign w_unused = ^{w_ashi_waddr[31:7], w_ashi_raddr[31:7],
                        w_ashi_wdata[31:16], w_ashi_wstrb[3:2]};

    always_comb begin
        // NOTE: every output gets a default before the decode, so no path
        // through the block leaves a value held and no latch is inferred.
        w_ashi_wresp = DECERR;
        w_cpp_we     = 1'b0;
        w_clear      = 1'b0;
        if (w_widx == REG_CYCLES_PER_PKT) begin
            w_ashi_wresp = OKAY;
            w_cpp_we     = w_ashi_write;
        end else if (w_widx == REG_CONTROL) begin
            w_ashi_wresp = OKAY;
            w_clear      = w_ashi_write && w_ashi_wstrb[0] && w_ashi_wdata[0];
        end
    end

    always_comb begin
        w_ashi_rdata = '0;
        w_ashi_rresp = OKAY;
        case (w_ridx)
            REG_MODULE_REV:     w_ashi_rdata = 32'(MODULE_VERSION);
            REG_PKT_COUNT_H:    w_ashi_rdata = r_pkt_count_h;
            REG_PKT_COUNT_L:    w_ashi_rdata = r_pkt_count[31:0];
            REG_CYCLES_PER_PKT: w_ashi_rdata = {16'h0000, r_cpp};
            REG_DATA_ERRS:      w_ashi_rdata = r_data_errs;
            REG_LEN_ERRS:       w_ashi_rdata = r_len_errs;
            REG_FIRST_BAD_SEQ:  w_ashi_rdata = r_first_bad;
            default:            w_ashi_rresp = DECERR;
        endcase
    end

    // Reading the low word freezes the high word of the same count value.
    assign w_latch_h = w_ashi_read && (w_ridx == REG_PKT_COUNT_L);

    assign w_accept   = AXIS_IN_TVALID && r_tready;
    assign w_cpp_live = (r_cpp == 16'd0) ? 16'd1 : r_cpp;
    // Beat 1 uses the live register; later beats the value latched at beat 1.
    assign w_cpp      = (r_beat == 16'd1) ? w_cpp_live : r_pkt_cpp;

    assign w_data_bad = r_data_bad
                      || (AXIS_IN_TDATA != {16{r_expected_seq[31:0]}})
                      || (AXIS_IN_TKEEP != '1);
    assign w_long     = !AXIS_IN_TLAST && (r_beat >= w_cpp);
    assign w_len_bad  = r_len_bad || w_long
                      || (AXIS_IN_TLAST && (r_beat < w_cpp));

    assign AXIS_IN_TREADY = r_tready;
    assign ERROR          = (r_data_errs != 32'd0) || (r_len_errs != 32'd0);

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: all checker state, including configuration, returns to its
        // reset value asynchronously; a partial packet is simply forgotten.
        if (!resetn) begin
            r_tready       <= 1'b0;
            r_expected_seq <= 64'd1;
            r_beat         <= 16'd1;
            r_pkt_cpp      <= 16'd1;
            r_data_bad     <= 1'b0;
            r_len_bad      <= 1'b0;
            r_pkt_count    <= '0;
            r_pkt_count_h  <= '0;
            r_data_errs    <= '0;
            r_len_errs     <= '0;
            r_first_bad    <= '0;
            r_cpp          <= 16'(DEFAULT_CYCLES_PER_PKT);
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees register values from before this edge.
            r_tready <= 1'b1;

            if (w_cpp_we) begin
                if (w_ashi_wstrb[0]) r_cpp[7:0]  <= w_ashi_wdata[7:0];
                if (w_ashi_wstrb[1]) r_cpp[15:8] <= w_ashi_wdata[15:8];
            end

            if (w_latch_h) begin
                r_pkt_count_h <= r_pkt_count[63:32];
            end

            // A clear on the same edge as an accepted beat discards the beat.
            if (w_clear) begin
                r_expected_seq <= 64'd1;
                r_beat         <= 16'd1;
                r_data_bad     <= 1'b0;
                r_len_bad      <= 1'b0;
                r_pkt_count    <= '0;
                r_pkt_count_h  <= '0;
                r_data_errs    <= '0;
                r_len_errs     <= '0;
                r_first_bad    <= '0;
            end else if (w_accept) begin
                if (r_beat == 16'd1) begin
                    r_pkt_cpp <= w_cpp_live;
                end
                if (AXIS_IN_TLAST) begin
                    r_pkt_count <= sat_inc64(r_pkt_count);
                    r_data_errs <= sat_inc32(r_data_errs, w_data_bad);
                    r_len_errs  <= sat_inc32(r_len_errs, w_len_bad);
                    if ((w_data_bad || w_len_bad) && (r_first_bad == 32'd0)) begin
                        r_first_bad <= r_expected_seq[31:0];
                    end
                    r_expected_seq <= r_expected_seq + 64'd1;
                    r_beat         <= 16'd1;
                    r_data_bad     <= 1'b0;
                    r_len_bad      <= 1'b0;
                end else begin
                    r_data_bad <= w_data_bad;
                    r_len_bad  <= w_len_bad;
                    // Overlong packets park the beat count at the limit.
                    if (!w_long) begin
                        r_beat <= r_beat + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_check.sv
// -----------------------------------------------------------------------------
// tb_packet_check
// Self-checking bench for packet_check. A reference model tracks the expected
// counters; every accepted TLAST pushes the expected ERROR level into a
// scoreboard queue that a monitor pops one edge later.
// -----------------------------------------------------------------------------
module tb_packet_check;
    import packet_check_pkg::*;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata  = '0;
    logic [3:0]   wstrb  = 4'hF;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b1;
    logic [31:0]  araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b1;
    logic [511:0] tdata  = '0;
    logic [63:0]  tkeep  = '1;
    logic         tlast  = 1'b0;
    logic         tvalid = 1'b0;
    logic         tready;
    logic         error;

    always #5 clk = ~clk;

    packet_check dut (
        .clk            (clk),
        .resetn         (resetn),
        .S_AXI_AWADDR   (awaddr),
        .S_AXI_AWPROT   (awprot),
        .S_AXI_AWVALID  (awvalid),
        .S_AXI_AWREADY  (awready),
        .S_AXI_WDATA    (wdata),
        .S_AXI_WSTRB    (wstrb),
        .S_AXI_WVALID   (wvalid),
        .S_AXI_WREADY   (wready),
        .S_AXI_BRESP    (bresp),
        .S_AXI_BVALID   (bvalid),
        .S_AXI_BREADY   (bready),
        .S_AXI_ARADDR   (araddr),
        .S_AXI_ARPROT   (arprot),
        .S_AXI_ARVALID  (arvalid),
        .S_AXI_ARREADY  (arready),
        .S_AXI_RDATA    (rdata),
        .S_AXI_RRESP    (rresp),
        .S_AXI_RVALID   (rvalid),
        .S_AXI_RREADY   (rready),
        .AXIS_IN_TDATA  (tdata),
        .AXIS_IN_TKEEP  (tkeep),
        .AXIS_IN_TLAST  (tlast),
        .AXIS_IN_TVALID (tvalid),
        .AXIS_IN_TREADY (tready),
        .ERROR          (error)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        exp_err_q[$];
    logic [63:0] m_exp_seq;
    logic [15:0] m_cpp;
    logic [15:0] m_pkt_cpp;
    int          m_nbeats;
    bit          m_dbad;
    logic [63:0] m_pkt;
    logic [31:0] m_de, m_le, m_fb;

    task automatic model_clear();
        m_exp_seq = 64'd1; m_nbeats = 0; m_dbad = 0;
        m_pkt = '0; m_de = '0; m_le = '0; m_fb = '0;
    endtask

    task automatic model_reset();
        model_clear();
        m_cpp = 16'd3;
        m_pkt_cpp = 16'd3;
        exp_err_q.delete();
    endtask

    task automatic model_beat(input logic [31:0] seq, input bit corrupt, input bit last);
        bit lbad;
        if (m_nbeats == 0) m_pkt_cpp = (m_cpp == 16'd0) ? 16'd1 : m_cpp;
        m_nbeats++;
        if (corrupt || (seq != m_exp_seq[31:0])) m_dbad = 1;
        if (last) begin
            lbad = (m_nbeats != int'(m_pkt_cpp));
            m_pkt++;
            if (m_dbad) m_de++;
            if (lbad) m_le++;
            if ((m_dbad || lbad) && (m_fb == 0)) m_fb = m_exp_seq[31:0];
            m_exp_seq++;
            m_nbeats = 0;
            m_dbad = 0;
            exp_err_q.push_back((m_de != 0) || (m_le != 0));
        end
    endtask

    // Scoreboard consumer: ERROR is due one edge after each accepted TLAST.
    always @(posedge clk) begin
        if (resetn && tvalid && tready && tlast) begin
            #1;
            if (exp_err_q.size() == 0) check("sb_queue_nonempty", 64'(exp_err_q.size()), 64'd1);
            else check("error_after_tlast", error, exp_err_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic send_beats(input logic [31:0] seq, input int n, input bit last,
                              input int bad_beat, input int bad_word, input bit bad_keep);
        for (int b = 1; b <= n; b++) begin
            logic [511:0] d;
            logic [63:0]  k;
            bit           corrupt;
            int           waited;
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                tvalid = 1'b0;
                @(negedge clk);
            end
            d = {16{seq}};
            k = '1;
            corrupt = 0;
            if (b == bad_beat) begin
                if (bad_keep) k[7] = 1'b0;
                else d[bad_word*32 +: 32] = d[bad_word*32 +: 32] ^ 32'h0000_0100;
                corrupt = 1;
            end
            tdata = d; tkeep = k; tlast = last && (b == n); tvalid = 1'b1;
            waited = 0;
            do begin
                @(posedge clk);
                waited++;
            end while (!tready && waited < 20);
            if (!tready) begin
                check("tready_timeout", tready, 1);
                break;
            end
            model_beat(seq, corrupt, tlast);
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int n);
        send_beats(m_exp_seq[31:0], n, 1, 0, 0, 0);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int w;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        w = 0;
        do begin
            @(posedge clk);
            w++;
        end while (!awready && w < 20);
        if (!awready) check("awready_timeout", awready, 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        w = 0;
        while (!bvalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bvalid) check("bvalid_timeout", bvalid, 1);
        resp = bresp;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int w;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        w = 0;
        do begin
            @(posedge clk);
            w++;
        end while (!arready && w < 20);
        if (!arready) check("arready_timeout", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        w = 0;
        while (!rvalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!rvalid) check("rvalid_timeout", rvalid, 1);
        data = rdata;
        resp = rresp;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read({25'd0, idx, 2'b00}, d, r);
        check(tag, d, exp);
    endtask

    task automatic wr_reg(input logic [4:0] idx, input logic [31:0] data);
        logic [1:0] r;
        axi_write({25'd0, idx, 2'b00}, data, r);
        check("wr_resp_okay", r, OKAY);
        if (idx == REG_CYCLES_PER_PKT) m_cpp = data[15:0];
        if (idx == REG_CONTROL && data[0]) model_clear();
    endtask

    task automatic check_model(input string tag);
        rd_check({tag, "_pkt_l"}, REG_PKT_COUNT_L, m_pkt[31:0]);
        rd_check({tag, "_pkt_h"}, REG_PKT_COUNT_H, m_pkt[63:32]);
        rd_check({tag, "_data_errs"}, REG_DATA_ERRS, m_de);
        rd_check({tag, "_len_errs"}, REG_LEN_ERRS, m_le);
        rd_check({tag, "_first_bad"}, REG_FIRST_BAD_SEQ, m_fb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        model_reset();

        // Reset state
        #1;
        check("reset_tready", tready, 0);
        check("reset_error", error, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1 check("tready_still_low_after_release", tready, 0);
        @(posedge clk);
        #1 check("tready_high_first_clk", tready, 1);
        rd_check("module_rev", REG_MODULE_REV, 32'd1);
        rd_check("cpp_default", REG_CYCLES_PER_PKT, 32'd3);

        // 1: clean stream, seq 1..10
        for (int i = 0; i < 10; i++) send_pkt(3);
        rd_check("t1_pkt_l", REG_PKT_COUNT_L, 32'd10);
        rd_check("t1_pkt_h", REG_PKT_COUNT_H, 32'd0);
        rd_check("t1_data_errs", REG_DATA_ERRS, 32'd0);
        rd_check("t1_len_errs", REG_LEN_ERRS, 32'd0);
        rd_check("t1_first_bad", REG_FIRST_BAD_SEQ, 32'd0);
        check("t1_error", error, 0);

        // 2: one corrupted word in packet 4 beat 2
        wr_reg(REG_CONTROL, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) send_beats(m_exp_seq[31:0], 3, 1, 2, 5, 0);
            else send_pkt(3);
        end
        rd_check("t2_pkt_l", REG_PKT_COUNT_L, 32'd8);
        rd_check("t2_data_errs", REG_DATA_ERRS, 32'd1);
        rd_check("t2_len_errs", REG_LEN_ERRS, 32'd0);
        rd_check("t2_first_bad", REG_FIRST_BAD_SEQ, 32'd4);
        check("t2_error", error, 1);

        // 3: short then long packet
        wr_reg(REG_CONTROL, 32'd1);
        wr_reg(REG_CYCLES_PER_PKT, 32'd3);
        send_pkt(3);
        send_pkt(2);
        send_pkt(5);
        rd_check("t3_pkt_l_after3", REG_PKT_COUNT_L, 32'd3);
        rd_check("t3_len_errs_after3", REG_LEN_ERRS, 32'd2);
        send_pkt(3);
        rd_check("t3_pkt_l", REG_PKT_COUNT_L, 32'd4);
        rd_check("t3_len_errs", REG_LEN_ERRS, 32'd2);
        rd_check("t3_data_errs", REG_DATA_ERRS, 32'd0);
        rd_check("t3_first_bad", REG_FIRST_BAD_SEQ, 32'd2);

        // 6: async reset mid-packet
        check("t6_error_before_reset", error, 1);
        send_beats(32'd5, 1, 0, 0, 0, 0);
        resetn = 1'b0;
        #1;
        check("t6_tready_async", tready, 0);
        check("t6_error_async", error, 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        #1 check("t6_tready_low_at_release", tready, 0);
        @(posedge clk);
        #1 check("t6_tready_back", tready, 1);
        check_model("t6_after_reset");
        rd_check("t6_cpp_default", REG_CYCLES_PER_PKT, 32'd3);
        send_beats(32'd5, 2, 1, 0, 0, 0);
        rd_check("t6_data_errs", REG_DATA_ERRS, 32'd1);
        rd_check("t6_len_errs", REG_LEN_ERRS, 32'd1);
        rd_check("t6_first_bad", REG_FIRST_BAD_SEQ, 32'd1);

        // 4: CONTROL clear on the same edge as a beat of packet 5
        wr_reg(REG_CONTROL, 32'd1);
        for (int i = 0; i < 4; i++) send_pkt(3);
        send_beats(32'd5, 1, 0, 0, 0, 0);
        @(negedge clk);
        tdata = {16{32'd5}}; tkeep = '1; tlast = 1'b0; tvalid = 1'b1;
        awaddr = {25'd0, REG_CONTROL, 2'b00}; wdata = 32'd1; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        check("t4_aw_same_edge", awready, 1);
        check("t4_beat_same_edge", tready, 1);
        @(negedge clk);
        tvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("t4_clear_bresp", bresp, OKAY);
        model_clear();
        check_model("t4_cleared");
        check("t4_error_cleared", error, 0);
        send_pkt(3);
        rd_check("t4_seq1_pkt_l", REG_PKT_COUNT_L, 32'd1);
        rd_check("t4_seq1_data_errs", REG_DATA_ERRS, 32'd0);

        // 5: coherent 64-bit count read across the 32-bit boundary
        force dut.r_pkt_count = 64'h0000_0000_FFFF_FFFF;
        rd_check("t5_l_before", REG_PKT_COUNT_L, 32'hFFFF_FFFF);
        force dut.r_pkt_count = 64'h0000_0001_0000_0000;
        rd_check("t5_h_shadow", REG_PKT_COUNT_H, 32'd0);
        rd_check("t5_l_after", REG_PKT_COUNT_L, 32'd0);
        rd_check("t5_h_after", REG_PKT_COUNT_H, 32'd1);
        release dut.r_pkt_count;
        wr_reg(REG_CONTROL, 32'd1);

        // Decode errors and read-only registers
        axi_write({25'd0, REG_MODULE_REV, 2'b00}, 32'h55, r);
        check("ro_write_decerr", r, DECERR);
        axi_write({25'd0, REG_PKT_COUNT_L, 2'b00}, 32'h55, r);
        check("ro_count_write_decerr", r, DECERR);
        rd_check("ro_rev_unchanged", REG_MODULE_REV, 32'd1);
        rd_check("ro_count_unchanged", REG_PKT_COUNT_L, 32'd0);
        axi_read(32'h0000_0040, d, r);
        check("bad_addr_read_decerr", r, DECERR);

        // CYCLES_PER_PKT change mid-packet applies from the next packet
        send_beats(m_exp_seq[31:0], 1, 0, 0, 0, 0);
        wr_reg(REG_CYCLES_PER_PKT, 32'd2);
        send_beats(m_exp_seq[31:0], 2, 1, 0, 0, 0);
        send_pkt(2);
        rd_check("cpp_mid_len_errs", REG_LEN_ERRS, 32'd0);

        // CYCLES_PER_PKT of 0 behaves as 1; TKEEP hole is a data error
        wr_reg(REG_CYCLES_PER_PKT, 32'd0);
        rd_check("cpp_zero_readback", REG_CYCLES_PER_PKT, 32'd0);
        send_pkt(1);
        send_pkt(1);
        send_beats(m_exp_seq[31:0], 1, 1, 1, 0, 1);
        check_model("final");

        repeat (3) @(negedge clk);
        check("sb_queue_drained", 64'(exp_err_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
